// File: rtl/sobel_vga_tx_if.sv
// Pixel input and video output bundle of sobel_vga_tx, plus FSM/FIFO debug taps.
// Handshake: pixel_in is taken on every clock with pixel_in_valid high; there is no ready, so a full buffer drops the pixel and raises overflow.
interface sobel_vga_tx_if #(
  parameter int FIFO_DEPTH = 1024
) ();
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    pixel_in;
  logic          pixel_in_valid;
  logic          pixel_in_sof;
  logic [7:0]    R;
  logic [7:0]    G;
  logic [7:0]    B;
  logic          HS;
  logic          VS;
  logic          DE;
  logic          frame_start;
  logic          locked;
  logic          underflow;
  logic          overflow;
  logic [1:0]    fsm_state;
  logic [FW-1:0] fill;

  modport master (
    output pixel_in, pixel_in_valid, pixel_in_sof,
    input  R, G, B, HS, VS, DE, frame_start, locked, underflow, overflow, fsm_state, fill
  );

  modport slave (
    input  pixel_in, pixel_in_valid, pixel_in_sof,
    output R, G, B, HS, VS, DE, frame_start, locked, underflow, overflow, fsm_state, fill
  );
endinterface

// File: rtl/sobel_vga_tx.sv
// VGA transmitter for a binary edge map: free-running timing, input pixel FIFO,
// and an UNLOCKED/ARMED/STREAMING lock FSM that places the image top-left of the active area.
module sobel_vga_tx #(
  parameter int VGA_pixels     = 800,
  parameter int VGA_lines      = 600,
  parameter int HS_sync        = 128,
  parameter int HS_back_porch  = 88,
  parameter int HS_front_porch = 40,
  parameter int VS_sync        = 4,
  parameter int VS_back_porch  = 23,
  parameter int VS_front_porch = 1,
  parameter int cols           = 512,
  parameter int rows           = 512,
  parameter int FIFO_DEPTH     = 1024,
  parameter int PRIME_LEVEL    = 512
) (
  input logic           clk,
  input logic           reset,
  sobel_vga_tx_if.slave bus
);
  localparam int CW = 16;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] H_LAST     = CW'(HS_sync + HS_back_porch + VGA_pixels + HS_front_porch - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(VS_sync + VS_back_porch + VGA_lines + VS_front_porch - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(HS_sync);
  localparam logic [CW-1:0] V_SYNC_END = CW'(VS_sync);
  localparam logic [CW-1:0] H_ACT      = CW'(HS_sync + HS_back_porch);
  localparam logic [CW-1:0] V_ACT      = CW'(VS_sync + VS_back_porch);
  localparam logic [CW-1:0] H_ACT_END  = CW'(HS_sync + HS_back_porch + VGA_pixels);
  localparam logic [CW-1:0] V_ACT_END  = CW'(VS_sync + VS_back_porch + VGA_lines);
  localparam logic [CW-1:0] H_WIN_END  = CW'(HS_sync + HS_back_porch + cols);
  localparam logic [CW-1:0] V_WIN_END  = CW'(VS_sync + VS_back_porch + rows);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PRIME_C    = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ARMED     = 2'd1,
    STREAMING = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fill;
  logic          empty;
  logic          full;
  logic          h_active;
  logic          v_active;
  logic          in_window;
  logic          frame_edge;
  logic          pop_req;
  logic          pop_do;
  logic          starved;
  logic          push_req;
  logic          push_do;
  logic [AW-1:0] wr_addr;
  logic [7:0]    pix_next;

  assign bus.fsm_state = state;
  assign bus.fill      = fill;

  always_comb begin
    fill       = wr_ptr - rd_ptr;
    empty      = (fill == '0);
    full       = (fill == DEPTH_C);
    h_active   = (h_count >= H_ACT) && (h_count < H_ACT_END);
    v_active   = (v_count >= V_ACT) && (v_count < V_ACT_END);
    in_window  = h_active && v_active && (h_count < H_WIN_END) && (v_count < V_WIN_END);
    frame_edge = (h_count == '0) && (v_count == '0);
    pop_req    = in_window && (state == STREAMING);
    pop_do     = pop_req && !empty;
    starved    = pop_req && empty;
    // While unlocked only a start-of-frame pixel gets in; it becomes entry 0 of a fresh buffer.
    push_req   = bus.pixel_in_valid && ((state != UNLOCKED) || bus.pixel_in_sof);
    push_do    = push_req && (!full || pop_do);
    wr_addr    = (state == UNLOCKED) ? '0 : wr_ptr[AW-1:0];
    pix_next   = pop_do ? mem[rd_ptr[AW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.HS          <= 1'b1;
      bus.VS          <= 1'b1;
      bus.DE          <= 1'b0;
      bus.R           <= 8'h00;
      bus.G           <= 8'h00;
      bus.B           <= 8'h00;
      bus.frame_start <= 1'b0;
    end else begin
      bus.HS          <= (h_count >= H_SYNC_END);
      bus.VS          <= (v_count >= V_SYNC_END);
      bus.DE          <= h_active && v_active;
      bus.R           <= pix_next;
      bus.G           <= pix_next;
      bus.B           <= pix_next;
      bus.frame_start <= frame_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (push_do) begin
      mem[wr_addr] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= UNLOCKED;
      bus.locked    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.underflow <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      if (push_req && full && !pop_do) begin
        bus.overflow <= 1'b1;
      end
      if (starved) begin
        bus.underflow <= 1'b1;
      end
      case (state)
        UNLOCKED: begin
          rd_ptr <= '0;
          wr_ptr <= push_do ? (AW+1)'(1) : '0;
          if (push_do) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (push_do) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          // Priming is judged on the occupancy present at the frame's first clock.
          if (frame_edge && (fill >= PRIME_C)) begin
            state      <= STREAMING;
            bus.locked <= 1'b1;
          end
        end
        STREAMING: begin
          if (push_do) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (pop_do) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (starved) begin
            state      <= UNLOCKED;
            bus.locked <= 1'b0;
          end
        end
        default: begin
          state      <= UNLOCKED;
          bus.locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_vga_tx.sv
// Bench for sobel_vga_tx on a shrunken video mode: per-clock reference model plus
// a vector table and hand-written lock/underflow/overflow/reset sequences.
module tb_sobel_vga_tx;
  localparam int VP = 16, VL = 8, HSY = 4, HBP = 3, HFP = 2, VSY = 2, VBP = 2, VFP = 1;
  localparam int COLS = 8, ROWS = 6, DEPTH = 128, PRIME = 32;
  localparam int HT = VP + HSY + HBP + HFP;
  localparam int VT = VL + VSY + VBP + VFP;
  localparam int FT = HT * VT;
  localparam int HA = HSY + HBP;
  localparam int VA = VSY + VBP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sobel_vga_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  sobel_vga_tx #(
    .VGA_pixels(VP), .VGA_lines(VL),
    .HS_sync(HSY), .HS_back_porch(HBP), .HS_front_porch(HFP),
    .VS_sync(VSY), .VS_back_porch(VBP), .VS_front_porch(VFP),
    .cols(COLS), .rows(ROWS), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n = 0;
  int mstate = 0;
  bit m_uf = 0;
  bit m_of = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         v;
    bit         s;
    logic [7:0] p;
    logic [3:0] video;
    int         fill;
    int         st;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s n=%0d got=%0d expected=%0d", name, n, act, exp);
    end
  endtask

  function automatic bit in_win(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return (h >= HA) && (h < HA + COLS) && (v >= VA) && (v < VA + ROWS);
  endfunction

  task automatic tick(input bit v_in, input bit s_in, input logic [7:0] p_in);
    int h, v, sz0, nxt;
    bit de, fs;
    logic [7:0] pix;
    bus.pixel_in_valid = v_in;
    bus.pixel_in_sof   = s_in;
    bus.pixel_in       = p_in;
    h   = n % HT;
    v   = (n / HT) % VT;
    de  = (h >= HA) && (h < HA + VP) && (v >= VA) && (v < VA + VL);
    fs  = (h == 0) && (v == 0);
    sz0 = exp_q.size();
    pix = 8'h00;
    nxt = mstate;
    if (in_win(n) && mstate == 2) begin
      if (exp_q.size() > 0) pix = exp_q.pop_front();
      else begin
        m_uf = 1;
        nxt  = 0;
      end
    end
    if (mstate == 0) begin
      exp_q.delete();
      if (v_in && s_in) begin
        exp_q.push_back(p_in);
        nxt = 1;
      end
    end else if (v_in) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(p_in);
      else m_of = 1;
    end
    if (mstate == 1 && fs && sz0 >= PRIME) nxt = 2;
    @(posedge clk);
    #1;
    chk("video", int'({bus.HS, bus.VS, bus.DE, bus.frame_start}), int'({h >= HSY, v >= VSY, de, fs}));
    chk("rgb", int'({bus.R, bus.G, bus.B}), int'({pix, pix, pix}));
    chk("locked", int'(bus.locked), int'(nxt == 2));
    chk("flags", int'({bus.underflow, bus.overflow}), int'({m_uf, m_of}));
    chk("fill", int'(bus.fill), exp_q.size());
    chk("state", int'(bus.fsm_state), nxt);
    mstate = nxt;
    n++;
  endtask

  task automatic do_reset(input int cycles);
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in_sof   = 1'b0;
    bus.pixel_in       = 8'h00;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_video", int'({bus.HS, bus.VS, bus.DE, bus.frame_start}), 12);
    chk("rst_rgb", int'({bus.R, bus.G, bus.B}), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_flags", int'({bus.underflow, bus.overflow}), 0);
    chk("rst_fill", int'(bus.fill), 0);
    chk("rst_state", int'(bus.fsm_state), 0);
    reset  = 1'b0;
    n      = 0;
    mstate = 0;
    m_uf   = 0;
    m_of   = 0;
    exp_q.delete();
  endtask

  int sizes[10]    = '{48, 48, 48, 20, 0, 20, 48, 48, 0, 0};
  int lock_end[10] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
  int uf_end[10]   = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    int hs_low, vs_low, de_hi, lk_hi, sent, first, second;
    bit go;
    logic [7:0] px;

    tbl[0] = '{1'b1, 1'b0, 8'hAA, 4'b0001, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 4'b0000, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 8'h22, 4'b0000, 2, 1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 4'b0000, 2, 1};
    tbl[4] = '{1'b1, 1'b1, 8'h33, 4'b1000, 3, 1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 4'b1000, 3, 1};

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].v, tbl[i].s, tbl[i].p);
      chk("tbl_video", int'({bus.HS, bus.VS, bus.DE, bus.frame_start}), int'(tbl[i].video));
      chk("tbl_fill", int'(bus.fill), tbl[i].fill);
      chk("tbl_state", int'(bus.fsm_state), tbl[i].st);
    end

    // Two idle frames: pure timing, nothing may lock.
    do_reset(1);
    hs_low = 0; vs_low = 0; de_hi = 0; lk_hi = 0;
    for (int k = 0; k < 2 * FT; k++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if (!bus.HS) hs_low++;
      if (!bus.VS) vs_low++;
      if (bus.DE) de_hi++;
      if (bus.locked) lk_hi++;
    end
    chk("idle_hs_low", hs_low, 2 * VT * HSY);
    chk("idle_vs_low", vs_low, 2 * VSY * HT);
    chk("idle_de_high", de_hi, 2 * VP * VL);
    chk("idle_locked", lk_hi, 0);

    // Image stream: ramp first, random data after, with starved and under-primed frames.
    do_reset(1);
    for (int f = 0; f < 10; f++) begin
      sent = 0;
      for (int c = 0; c < FT; c++) begin
        go = (sent < sizes[f]) && (($urandom_range(0, 3) != 0) || (FT - c <= sizes[f] - sent));
        if (go) begin
          px = (f == 0) ? 8'(sent % COLS) : 8'($urandom_range(0, 255));
          tick(1'b1, sent == 0, px);
          sent++;
        end else begin
          tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
      end
      chk("frame_locked", int'(bus.locked), lock_end[f]);
      chk("frame_underflow", int'(bus.underflow), uf_end[f]);
    end

    // Full buffer: push+pop together keeps occupancy, then plain pushes overflow.
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, i == 0, 8'($urandom_range(0, 255)));
    while (n < FT) tick(1'b0, 1'b0, 8'h00);
    while (n < 2 * FT) tick(in_win(n), 1'b0, 8'($urandom_range(0, 255)));
    chk("full_fill", int'(bus.fill), DEPTH);
    chk("full_no_ovf", int'(bus.overflow), 0);
    chk("full_locked", int'(bus.locked), 1);
    repeat (6) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    chk("ovf_fill", int'(bus.fill), DEPTH);
    chk("ovf_set", int'(bus.overflow), 1);

    // One-clock reset mid-window while streaming.
    while ((n % FT) != 6 * HT + 12) tick(1'b0, 1'b0, 8'h00);
    chk("pre_rst_locked", int'(bus.locked), 1);
    do_reset(1);
    first = -1;
    second = -1;
    for (int k = 0; k < 2 * FT; k++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (bus.frame_start) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("fs_first", first, 0);
    chk("fs_period", second, FT);

    // Overflow while armed, mid-frame.
    do_reset(1);
    repeat (100) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 6; i++) tick(1'b1, i == 0, 8'($urandom_range(0, 255)));
    chk("armed_ovf_fill", int'(bus.fill), DEPTH);
    chk("armed_ovf_flag", int'(bus.overflow), 1);
    chk("armed_ovf_state", int'(bus.fsm_state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
